csr_conv_scheduler: RTL and testbench
=====================================

// Module: csr_conv_scheduler
// PURPOSE
//  Sequences sparse convolution over one CSR-encoded frame. Accepts the CSR nonzero
//  stream (value, col, row) from the encoder/buffer and, per entry, walks all
//  kernel_size x kernel_size taps. Each tap whose output coordinate is in range
//  issues one scatter-accumulate command to the downstream MAC/accumulator array.
//  Output map is "valid" convolution, OUT = image_size-kernel_size+1 per side.
// PARAMETERS
//  word_length   8   width of CSR value and mac_value
//  col_length    8   width of row/col coordinates, input and output
//  kernel_size   5   kernel side K; taps indexed kidx = ky*K+kx
//  image_size    36  input side; localparam OUT = image_size-kernel_size+1 (32)
//  kidx_width    5   width of mac_kidx, >= clog2(K*K)
//  count_width   16  width of entry_count / cmd_count
// PORTS
//  clk          in   1            clock, rising edge
//  rst          in   1            reset, asynchronous, active-high
//  start        in   1            frame start pulse, honoured only in IDLE
//  entry_valid  in   1            CSR entry available
//  entry_ready  out  1            scheduler accepts entry (FETCH state only)
//  entry_value  in   word_length  nonzero value
//  entry_row    in   col_length   input row r
//  entry_col    in   col_length   input col c
//  entry_last   in   1            entry is final entry of frame
//  mac_valid    out  1            command valid
//  mac_ready    in   1            MAC accepts command
//  mac_value    out  word_length  latched entry value
//  mac_kidx     out  kidx_width   kernel tap index ky*K+kx
//  mac_out_row  out  col_length   r-ky
//  mac_out_col  out  col_length   c-kx
//  busy         out  1            high in any state except IDLE
//  done         out  1            one-cycle pulse, frame complete
//  entry_count  out  count_width  entries accepted this frame
//  cmd_count    out  count_width  MAC commands accepted this frame
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; latched entry, ky, kx, last flag, counters 0.
//  States: IDLE -> FETCH on start (counters cleared same edge).
//   FETCH: entry_ready=1; on entry_valid&entry_ready latch value/row/col/last,
//     ky=kx=0, -> ISSUE. No other state asserts entry_ready.
//   ISSUE: tap (ky,kx) valid iff r>=ky, c>=kx, r-ky<=OUT-1, c-kx<=OUT-1; compare
//     in col_length+1 bits, no wrap. Valid tap: mac_valid=1, mac_* driven from
//     latched regs + tap; all mac_* held stable until mac_ready. Tap advances on
//     mac_valid&mac_ready, or unconditionally in 1 cycle if tap invalid (mac_valid=0).
//     Advance: kx++, at kx=K-1 wrap kx=0 and ky++. After tap (K-1,K-1) advances:
//     last flag set -> DONE, else -> FETCH.
//   DONE: done=1 for exactly one cycle -> IDLE. busy=0 from IDLE onward.
//  Timing: entry handshake at edge t -> tap 0 presented in cycle t+1; with
//   mac_ready=1 one tap per cycle, each entry costs K*K+1 cycles incl. FETCH.
//  mac_ready low stalls only the current valid tap; each stall cycle adds 1 cycle.
//  Counters: entry_count ++ per accepted entry, cmd_count ++ per accepted command;
//   saturate at all-ones; hold value after done until next start.
//  start while busy: ignored. entry_valid outside FETCH: ignored, no accept.
//  mac_ready while mac_valid=0: no effect. Entry with value 0 processed normally.
//  rst mid-frame: immediate return to IDLE, partial frame discarded, no done.
// TESTING
//  1 K=5,img=36; one entry (10,10,val 7,last), mac_ready=1 -> 25 cmds kidx 0..24,
//    out_row=10-ky, out_col=10-kx, mac_value=7; done at 26th cycle after accept; cmd_count=25.
//  2 entry (0,0,last) -> single cmd kidx 0 out (0,0); 24 taps skipped silently;
//    done timing as test 1; cmd_count=1.
//  3 entry (35,35,last) -> single cmd kidx 24 out (31,31); cmd_count=1.
//  4 entry (10,10), mac_ready low 3 cycles at kidx 7 -> mac_* stable for 4 cycles,
//    no skipped/dup taps, done 3 cycles later than test 1.
//  5 3-entry frame with 2-cycle entry_valid gaps, start re-pulsed mid-frame ->
//    entry_ready only in FETCH, start ignored, entry_count=3, exactly one done.
//  6 rst during ISSUE of entry 2 -> all outputs 0 next cycle, IDLE, no done;
//    fresh start + 1-entry frame completes as test 1.

Source files
------------

// File: rtl/csr_conv_scheduler_if.sv
// Handshake bundle between the CSR entry source / MAC array and the scheduler.
//   start                          frame start pulse
//   entry_valid/ready/value/row/col/last   CSR nonzero entry stream
//   mac_valid/ready/value/kidx/out_row/out_col   scatter-accumulate commands
//   busy, done, entry_count, cmd_count    status
// Modport slave is the scheduler; modport master is the side driving entries
// and accepting MAC commands.
interface csr_conv_scheduler_if #(
    parameter int word_length = 8,
    parameter int col_length  = 8,
    parameter int kidx_width  = 5,
    parameter int count_width = 16
);
    logic                   start;
    logic                   entry_valid;
    logic                   entry_ready;
    logic [word_length-1:0] entry_value;
    logic [col_length-1:0]  entry_row;
    logic [col_length-1:0]  entry_col;
    logic                   entry_last;
    logic                   mac_valid;
    logic                   mac_ready;
    logic [word_length-1:0] mac_value;
    logic [kidx_width-1:0]  mac_kidx;
    logic [col_length-1:0]  mac_out_row;
    logic [col_length-1:0]  mac_out_col;
    logic                   busy;
    logic                   done;
    logic [count_width-1:0] entry_count;
    logic [count_width-1:0] cmd_count;

    modport slave (
        input  start, entry_valid, entry_value, entry_row, entry_col, entry_last, mac_ready,
        output entry_ready, mac_valid, mac_value, mac_kidx, mac_out_row, mac_out_col,
               busy, done, entry_count, cmd_count
    );

    modport master (
        output start, entry_valid, entry_value, entry_row, entry_col, entry_last, mac_ready,
        input  entry_ready, mac_valid, mac_value, mac_kidx, mac_out_row, mac_out_col,
               busy, done, entry_count, cmd_count
    );
endinterface

// File: rtl/csr_conv_scheduler.sv
// Sparse convolution scheduler for one CSR-encoded frame. Each accepted entry
// (value, row, col) is expanded into kernel_size x kernel_size taps; every tap
// whose output coordinate lands inside the valid-convolution output map issues
// one scatter-accumulate command (value, kidx, out_row, out_col) to the MAC array.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  csr_conv_scheduler_if.slave: start, entry stream, MAC command stream, status
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; counters hold last frame's totals
// S_FETCH | entry_ready high, waiting for the next CSR entry
// S_ISSUE | walking taps (ky,kx) of the latched entry
// S_DONE  | one-cycle done pulse, then back to idle
module csr_conv_scheduler #(
    parameter int word_length = 8,
    parameter int col_length  = 8,
    parameter int kernel_size = 5,
    parameter int image_size  = 36,
    parameter int kidx_width  = 5,
    parameter int count_width = 16
) (
    input logic                 clk,
    input logic                 rst,
    csr_conv_scheduler_if.slave bus
);
    localparam int OUT = image_size - kernel_size + 1;
    localparam int KW  = (kernel_size > 1) ? $clog2(kernel_size) : 1;
    localparam logic [col_length:0] OUT_MAX = (col_length + 1)'(OUT - 1);
    localparam logic [KW-1:0]       K_LAST  = KW'(kernel_size - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [word_length-1:0] r_value;
    logic [col_length-1:0]  r_row;
    logic [col_length-1:0]  r_col;
    logic                   r_last;
    logic [KW-1:0]          r_ky;
    logic [KW-1:0]          r_kx;
    logic [count_width-1:0] r_entry_count;
    logic [count_width-1:0] r_cmd_count;

    logic                   w_entry_ready;
    logic                   w_busy;
    logic                   w_done;
    logic                   w_in_issue;
    logic                   w_tap_valid;
    logic                   w_mac_valid;
    logic                   w_entry_fire;
    logic                   w_cmd_fire;
    logic                   w_tap_adv;
    logic                   w_last_tap;
    logic                   w_frame_clear;
    logic [col_length:0]    w_ky_ext;
    logic [col_length:0]    w_kx_ext;
    logic [col_length:0]    w_orow_ext;
    logic [col_length:0]    w_ocol_ext;
    logic [kidx_width-1:0]  w_kidx;

    // One extra bit so r-ky never wraps: an underflowing tap is rejected by the
    // r>=ky term and the upper-bound check sees the true difference.
    assign w_ky_ext    = (col_length + 1)'(r_ky);
    assign w_kx_ext    = (col_length + 1)'(r_kx);
    assign w_orow_ext  = {1'b0, r_row} - w_ky_ext;
    assign w_ocol_ext  = {1'b0, r_col} - w_kx_ext;
    assign w_tap_valid = ({1'b0, r_row} >= w_ky_ext) && ({1'b0, r_col} >= w_kx_ext) &&
                         (w_orow_ext <= OUT_MAX) && (w_ocol_ext <= OUT_MAX);
    assign w_kidx      = kidx_width'(r_ky) * kidx_width'(kernel_size) + kidx_width'(r_kx);

    assign w_in_issue    = (r_state == S_ISSUE);
    assign w_mac_valid   = w_in_issue && w_tap_valid;
    assign w_cmd_fire    = w_mac_valid && bus.mac_ready;
    assign w_entry_fire  = w_entry_ready && bus.entry_valid;
    // Out-of-range taps are skipped in a single cycle without waiting on mac_ready.
    assign w_tap_adv     = w_in_issue && (!w_tap_valid || bus.mac_ready);
    assign w_last_tap    = (r_ky == K_LAST) && (r_kx == K_LAST);
    assign w_frame_clear = (r_state == S_IDLE) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_entry_ready = 1'b0;
        w_busy        = 1'b1;
        w_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_entry_ready = 1'b1;
                if (bus.entry_valid) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_tap_adv && w_last_tap) w_state_nxt = r_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_last  <= 1'b0;
            r_ky    <= '0;
            r_kx    <= '0;
        end else if (w_entry_fire) begin
            r_value <= bus.entry_value;
            r_row   <= bus.entry_row;
            r_col   <= bus.entry_col;
            r_last  <= bus.entry_last;
            r_ky    <= '0;
            r_kx    <= '0;
        end else if (w_tap_adv) begin
            if (w_last_tap) begin
                r_ky <= '0;
                r_kx <= '0;
            end else if (r_kx == K_LAST) begin
                r_kx <= '0;
                r_ky <= r_ky + KW'(1);
            end else begin
                r_kx <= r_kx + KW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry_count <= '0;
            r_cmd_count   <= '0;
        end else if (w_frame_clear) begin
            r_entry_count <= '0;
            r_cmd_count   <= '0;
        end else begin
            if (w_entry_fire && (r_entry_count != '1)) r_entry_count <= r_entry_count + count_width'(1);
            if (w_cmd_fire && (r_cmd_count != '1))     r_cmd_count   <= r_cmd_count + count_width'(1);
        end
    end

    assign bus.entry_ready = w_entry_ready;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.mac_valid   = w_mac_valid;
    assign bus.mac_value   = w_mac_valid ? r_value : '0;
    assign bus.mac_kidx    = w_mac_valid ? w_kidx : '0;
    assign bus.mac_out_row = w_mac_valid ? w_orow_ext[col_length-1:0] : '0;
    assign bus.mac_out_col = w_mac_valid ? w_ocol_ext[col_length-1:0] : '0;
    assign bus.entry_count = r_entry_count;
    assign bus.cmd_count   = r_cmd_count;
endmodule

// File: tb/tb_csr_conv_scheduler.sv
module tb_csr_conv_scheduler;
    localparam int WL  = 8;
    localparam int CL  = 8;
    localparam int K   = 5;
    localparam int IMG = 36;
    localparam int KIW = 5;
    localparam int CW  = 16;
    localparam int OUT = IMG - K + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_conv_scheduler_if #(.word_length(WL), .col_length(CL), .kidx_width(KIW), .count_width(CW)) bus ();

    csr_conv_scheduler #(
        .word_length(WL), .col_length(CL), .kernel_size(K),
        .image_size(IMG), .kidx_width(KIW), .count_width(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic use_rand  = 1'b0;
    logic rdy_rand  = 1'b1;
    logic rdy_force = 1'b1;
    assign bus.mac_ready = use_rand ? rdy_rand : rdy_force;

    typedef struct packed {
        logic [WL-1:0]  value;
        logic [KIW-1:0] kidx;
        logic [CL-1:0]  orow;
        logic [CL-1:0]  ocol;
    } cmd_t;

    typedef struct {
        int r; int c; int v;
        int stall_kidx; int stall_len;
        int n_cmds; int last_kidx; int lat;
    } vec_t;

    cmd_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   cmd_seen = 0;
    int   done_seen = 0;
    int   last_kidx_seen = -1;
    logic prev_stall = 1'b0;
    cmd_t prev_cmd;
    cmd_t cur_cmd;
    cmd_t exp_cmd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference: every tap whose output coordinate falls inside the OUT x OUT map,
    // in row-major tap order.
    function automatic void model_push(int r, int c, int v);
        cmd_t e;
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
                int orow = r - ky;
                int ocol = c - kx;
                if (orow >= 0 && orow < OUT && ocol >= 0 && ocol < OUT) begin
                    e.value = WL'(v);
                    e.kidx  = KIW'(ky * K + kx);
                    e.orow  = CL'(orow);
                    e.ocol  = CL'(ocol);
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    function automatic int model_count(int r, int c);
        int n = 0;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                if (r - ky >= 0 && r - ky < OUT && c - kx >= 0 && c - kx < OUT) n++;
        return n;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        rdy_rand <= ($urandom_range(0, 3) != 0);
    end

    // Monitor: scoreboard of MAC commands, stall stability, entry/done bookkeeping.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            cur_cmd.value = bus.mac_value;
            cur_cmd.kidx  = bus.mac_kidx;
            cur_cmd.orow  = bus.mac_out_row;
            cur_cmd.ocol  = bus.mac_out_col;
            if (prev_stall) begin
                check("stall_valid_held", 32'(bus.mac_valid), 32'd1);
                check("stall_cmd_held", 32'(cur_cmd), 32'(prev_cmd));
            end
            if (bus.entry_ready) check("entry_ready_exclusive", 32'(bus.mac_valid | bus.done), 32'd0);
            if (bus.entry_valid && bus.entry_ready)
                model_push(int'(bus.entry_row), int'(bus.entry_col), int'(bus.entry_value));
            if (bus.mac_valid && bus.mac_ready) begin
                cmd_seen++;
                last_kidx_seen = int'(bus.mac_kidx);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: got kidx %0d row %0d col %0d, expected no command",
                             bus.mac_kidx, bus.mac_out_row, bus.mac_out_col);
                end else begin
                    exp_cmd = exp_q.pop_front();
                    check("cmd", 32'(cur_cmd), 32'(exp_cmd));
                end
            end
            if (bus.done) done_seen++;
            prev_stall = bus.mac_valid && !bus.mac_ready;
            prev_cmd   = cur_cmd;
        end
    end

    task automatic start_frame();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_entry(input int r, input int c, input int v, input bit last,
                              input int gap, output int acc_cyc);
        bit accepted = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.entry_valid = 1'b1;
        bus.entry_row   = CL'(r);
        bus.entry_col   = CL'(c);
        bus.entry_value = WL'(v);
        bus.entry_last  = last;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.entry_ready) begin accepted = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.entry_valid = 1'b0;
        acc_cyc = cyc;
        if (!accepted) check("entry_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int acc, output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.done) begin lat = cyc - acc + 1; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},        32'(bus.busy), 32'd0);
        check({tag, "_done"},        32'(bus.done), 32'd0);
        check({tag, "_entry_ready"}, 32'(bus.entry_ready), 32'd0);
        check({tag, "_mac_valid"},   32'(bus.mac_valid), 32'd0);
        check({tag, "_mac_fields"},  32'({bus.mac_value, bus.mac_kidx, bus.mac_out_row, bus.mac_out_col}), 32'd0);
        check({tag, "_counts"},      32'({bus.entry_count, bus.cmd_count}), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int acc, lat, cs, ds, total, n, r, c;
        vecs[0] = '{r:10,  c:10,  v:7,   stall_kidx:-1, stall_len:0, n_cmds:25, last_kidx:24, lat:26};
        vecs[1] = '{r:0,   c:0,   v:9,   stall_kidx:-1, stall_len:0, n_cmds:1,  last_kidx:0,  lat:26};
        vecs[2] = '{r:35,  c:35,  v:3,   stall_kidx:-1, stall_len:0, n_cmds:1,  last_kidx:24, lat:26};
        vecs[3] = '{r:0,   c:35,  v:0,   stall_kidx:-1, stall_len:0, n_cmds:1,  last_kidx:4,  lat:26};
        vecs[4] = '{r:2,   c:3,   v:200, stall_kidx:-1, stall_len:0, n_cmds:12, last_kidx:13, lat:26};
        vecs[5] = '{r:33,  c:1,   v:5,   stall_kidx:-1, stall_len:0, n_cmds:6,  last_kidx:21, lat:26};
        vecs[6] = '{r:10,  c:10,  v:7,   stall_kidx:7,  stall_len:3, n_cmds:25, last_kidx:24, lat:29};
        vecs[7] = '{r:200, c:200, v:1,   stall_kidx:-1, stall_len:0, n_cmds:0,  last_kidx:-1, lat:26};

        bus.start = 1'b0; bus.entry_valid = 1'b0; bus.entry_value = '0;
        bus.entry_row = '0; bus.entry_col = '0; bus.entry_last = 1'b0;

        repeat (3) @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");
        @(posedge clk); #1;

        // Single-entry frames from the vector table.
        for (int i = 0; i < 8; i++) begin
            start_frame();
            cs = cmd_seen; ds = done_seen; last_kidx_seen = -1;
            send_entry(vecs[i].r, vecs[i].c, vecs[i].v, 1'b1, 0, acc);
            if (vecs[i].stall_kidx >= 0) begin
                for (int j = 0; j < 100; j++) begin
                    @(negedge clk);
                    if (bus.mac_valid && int'(bus.mac_kidx) == vecs[i].stall_kidx - 1) break;
                end
                @(posedge clk); #1;
                rdy_force = 1'b0;
                repeat (vecs[i].stall_len) @(posedge clk);
                #1;
                rdy_force = 1'b1;
            end
            wait_done(acc, lat);
            check($sformatf("vec%0d_done_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_cmds_seen", i), 32'(cmd_seen - cs), 32'(vecs[i].n_cmds));
            check($sformatf("vec%0d_last_kidx", i), 32'(last_kidx_seen), 32'(vecs[i].last_kidx));
            check($sformatf("vec%0d_cmd_count", i), 32'(bus.cmd_count), 32'(vecs[i].n_cmds));
            check($sformatf("vec%0d_entry_count", i), 32'(bus.entry_count), 32'd1);
            check($sformatf("vec%0d_done_pulses", i), 32'(done_seen - ds), 32'd1);
            check($sformatf("vec%0d_queue_empty", i), 32'(exp_q.size()), 32'd0);
            check($sformatf("vec%0d_idle", i), 32'(bus.busy), 32'd0);
        end

        // Three entries with gaps and a start pulse while busy.
        start_frame();
        ds = done_seen;
        send_entry(4, 4, 11, 1'b0, 0, acc);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("mid_start_busy", 32'(bus.busy), 32'd1);
        send_entry(20, 6, 22, 1'b0, 2, acc);
        send_entry(30, 30, 33, 1'b1, 2, acc);
        wait_done(acc, lat);
        check("multi_done_latency", 32'(lat), 32'd26);
        check("multi_entry_count", 32'(bus.entry_count), 32'd3);
        check("multi_cmd_count", 32'(bus.cmd_count), 32'(model_count(4, 4) + model_count(20, 6) + model_count(30, 30)));
        repeat (5) @(posedge clk);
        #1;
        check("multi_done_pulses", 32'(done_seen - ds), 32'd1);
        check("multi_counts_held", 32'(bus.entry_count), 32'd3);
        check("multi_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while issuing the second entry.
        start_frame();
        ds = done_seen;
        send_entry(5, 5, 1, 1'b0, 0, acc);
        send_entry(12, 12, 2, 1'b0, 0, acc);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_quiet("midframe_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("midframe_reset_no_done", 32'(done_seen - ds), 32'd0);
        check("midframe_reset_idle", 32'(bus.busy), 32'd0);
        start_frame();
        cs = cmd_seen;
        send_entry(10, 10, 7, 1'b1, 0, acc);
        wait_done(acc, lat);
        check("after_reset_latency", 32'(lat), 32'd26);
        check("after_reset_cmd_count", 32'(bus.cmd_count), 32'd25);
        check("after_reset_cmds_seen", 32'(cmd_seen - cs), 32'd25);

        // Randomized frames with random MAC backpressure.
        use_rand = 1'b1;
        for (int f = 0; f < 20; f++) begin
            start_frame();
            ds = done_seen;
            total = 0;
            n = $urandom_range(1, 4);
            for (int e = 0; e < n; e++) begin
                r = $urandom_range(0, 40);
                c = $urandom_range(0, 40);
                if ($urandom_range(0, 7) == 0) r = $urandom_range(0, 255);
                if ($urandom_range(0, 7) == 0) c = $urandom_range(0, 255);
                total += model_count(r, c);
                send_entry(r, c, $urandom_range(0, 255), (e == n - 1), $urandom_range(0, 2), acc);
            end
            wait_done(acc, lat);
            check($sformatf("rand%0d_done_seen", f), 32'(lat > 0), 32'd1);
            check($sformatf("rand%0d_entry_count", f), 32'(bus.entry_count), 32'(n));
            check($sformatf("rand%0d_cmd_count", f), 32'(bus.cmd_count), 32'(total));
            check($sformatf("rand%0d_done_pulses", f), 32'(done_seen - ds), 32'd1);
            check($sformatf("rand%0d_queue_empty", f), 32'(exp_q.size()), 32'd0);
        end
        use_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
